uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter DBIT, default 8, number of data bits per frame (range 5..8).
REQ-002 Parameter OS, default 16, s_tick periods per start/data bit.
REQ-003 Parameter SB_TICK, default 16, s_tick periods in stop interval (16/24/32 = 1/1.5/2 stop bits at OS=16).
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 s_tick  input  1  one-clk oversample strobe (baud generator max_tick); sole pacing source.
REQ-007 tx_start  input  1  request to send din; sampled every clk.
REQ-008 din  input  DBIT  parallel data word, LSB transmitted first.
REQ-009 tx_busy  output  1  high whenever state is not IDLE.
REQ-010 tx_done_tick  output  1  one-clk pulse at frame completion.
REQ-011 tx  output  1  serial line, idle high, driven directly from a register.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; internal registers: tick counter s (width ceil(log2(max(OS,SB_TICK)))), bit counter n (width ceil(log2(DBIT))), shift register b (DBIT bits), tx_reg.
REQ-013 IDLE: tx=1; tx_start=1 -> b<=din, s<=0, go START, tx<=0 on that same edge; s_tick irrelevant.
REQ-014 tx_start in START/DATA/STOP SHALL be ignored; din SHALL not be resampled mid-frame.
REQ-015 START: tx=0; each s_tick: s==OS-1 -> s<=0, n<=0, go DATA, tx<=b[0]; else s<=s+1.
REQ-016 DATA: tx=b[0]; each s_tick: s==OS-1 -> s<=0, b<=b>>1; n==DBIT-1 -> go STOP, tx<=1; else n<=n+1, tx<=next b[0]; otherwise s<=s+1.
REQ-017 STOP: tx=1; each s_tick: s==SB_TICK-1 -> go IDLE, tx_done_tick<=1; else s<=s+1.
REQ-018 Cycles without s_tick SHALL hold s, n, b, state and tx unchanged.
REQ-019 tx_done_tick SHALL be high for exactly the first clk cycle back in IDLE, low otherwise.
REQ-020 tx_start high in the tx_done_tick cycle SHALL be accepted (back-to-back frames, no extra idle time).
REQ-021 Frame length SHALL be exactly (1+DBIT)*OS + SB_TICK s_ticks from tx falling to return to IDLE.
REQ-022 tx_busy SHALL be combinational decode of state; rises on edge accepting tx_start, falls on edge entering IDLE.
REQ-023 Counters SHALL never exceed their terminal values; no wrap through undefined states; unreachable state encodings SHALL return to IDLE.

Reset
REQ-024 reset=1 SHALL immediately force state=IDLE, s=0, n=0, b=0, tx=1, tx_busy=0, tx_done_tick=0, independent of clk.
REQ-025 Reset mid-frame SHALL abort the frame: tx high at once, no tx_done_tick, next frame needs new tx_start after reset release.

Verification
REQ-026 Defaults, s_tick every clk, din=0x55, tx_start 1 cycle -> tx: 0 for 16 cycles, then 1,0,1,0,1,0,1,0 x16 each, 1 for 16; tx_done_tick one cycle after 160 s_ticks; tx_busy high 160 cycles.
REQ-027 s_tick every 4th clk (baud generator M=4), din=0xA3 -> each bit 64 clk cycles, data order 1,1,0,0,0,1,0,1; total frame 640 clk cycles.
REQ-028 tx_start pulsed with din=0xFF during DATA of 0x00 frame -> frame stays 0x00 bits, no second frame, single tx_done_tick.
REQ-029 tx_start held high continuously, din=0x0F then 0xF0 -> two frames back-to-back, tx never idles between STOP and next START, two tx_done_tick pulses 160 s_ticks apart.
REQ-030 reset asserted at 3rd data bit -> tx=1, tx_busy=0 within same cycle, no tx_done_tick; after release, idle until tx_start.
REQ-031 SB_TICK=32, DBIT=7, din=0x41 -> 7 data bits 1,0,0,0,0,0,1, stop high 32 s_ticks, frame 160 s_ticks.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
//
// UART transmit controller. It serialises one DBIT-wide word per frame: a start
// bit (low), DBIT data bits LSB first, then a stop interval (high). An external
// baud generator supplies the timing through a one-clock oversample strobe,
// s_tick. Each start or data bit lasts OS strobes and the stop interval lasts
// SB_TICK strobes, so 1, 1.5 or 2 stop bits come from SB_TICK = OS, 1.5*OS or
// 2*OS.
//
// Parameters
//   DBIT     data bits per frame (5..8)
//   OS       s_tick periods per start/data bit
//   SB_TICK  s_tick periods in the stop interval
//
// Ports
//   clk           in   system clock, all state changes on the rising edge
//   reset         in   asynchronous, active-high; aborts any frame in flight
//   s_tick        in   oversample strobe, the only thing that paces a frame
//   tx_start      in   request to send din; acted on only while idle
//   din[DBIT]     in   parallel word, captured on the edge that accepts it
//   tx_busy       out  high while a frame is in progress (decode of state)
//   tx_done_tick  out  one-clock pulse in the first idle cycle after a frame
//   tx            out  serial line, idle high, driven straight from a flop
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
  parameter int DBIT    = 8,
  parameter int OS      = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);

  // The tick counter is shared by the bit intervals and the stop interval,
  // so it must be wide enough for whichever of the two is longer.
  localparam int S_MAX = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int SW    = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

  // Terminal counts, sized to their counters so every comparison is
  // width-matched.
  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OS - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  state_t          state_reg;
  logic [SW-1:0]   s_reg;     // s_tick count inside the current interval
  logic [NW-1:0]   n_reg;     // index of the data bit on the line
  logic [DBIT-1:0] b_reg;     // remaining data bits, next one at bit 0
  logic            tx_reg;
  logic            done_reg;

  // Shift register contents after one right shift. Bit 0 of this vector is
  // the value the line takes when a data bit ends, so tx can be loaded on the
  // same edge as b and never lags the data by a cycle.
  logic [DBIT-1:0] b_shift;

  genvar gi;
  generate
    for (gi = 0; gi < DBIT; gi++) begin : g_shift
      if (gi == DBIT - 1) begin : g_msb
        assign b_shift[gi] = 1'b0;
      end else begin : g_body
        assign b_shift[gi] = b_reg[gi + 1];
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Frame sequencer. tx and tx_done_tick are registered here, so the line
  // changes on the same edge as the state that owns it and no decode glitch
  // can reach the pin.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      tx_reg    <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      // The done strobe is asserted only on the STOP -> IDLE edge, which
      // makes it exactly one cycle wide.
      done_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          tx_reg <= 1'b1;
          // s_tick plays no part here: the start bit goes out on the very
          // edge that accepts the request. The request is also honoured in
          // the cycle that carries tx_done_tick, so frames can run back to
          // back without an idle gap.
          if (tx_start) begin
            state_reg <= START;
            b_reg     <= din;
            s_reg     <= '0;
            tx_reg    <= 1'b0;
          end
        end

        START: begin
          if (s_tick) begin
            // >= rather than == so a corrupted count still finishes the
            // interval instead of wrapping through the whole range.
            if (s_reg >= S_BIT_LAST) begin
              s_reg     <= '0;
              n_reg     <= '0;
              state_reg <= DATA;
              tx_reg    <= b_reg[0];
            end else begin
              s_reg <= s_reg + SW'(1);
            end
          end
        end

        DATA: begin
          if (s_tick) begin
            if (s_reg >= S_BIT_LAST) begin
              s_reg <= '0;
              b_reg <= b_shift;
              if (n_reg >= N_LAST) begin
                state_reg <= STOP;
                tx_reg    <= 1'b1;
              end else begin
                n_reg  <= n_reg + NW'(1);
                tx_reg <= b_shift[0];
              end
            end else begin
              s_reg <= s_reg + SW'(1);
            end
          end
        end

        STOP: begin
          if (s_tick) begin
            if (s_reg >= S_STOP_LAST) begin
              // Clearing s here keeps the counter at zero while idle; the
              // next accepted request clears it again anyway.
              s_reg     <= '0;
              state_reg <= IDLE;
              done_reg  <= 1'b1;
            end else begin
              s_reg <= s_reg + SW'(1);
            end
          end
        end

        // Every 2-bit code is a named state today; this arm keeps the
        // recovery path if the encoding is ever widened.
        default: begin
          state_reg <= IDLE;
          s_reg     <= '0;
          n_reg     <= '0;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

  // Busy is a pure decode of the state register, so it rises on the edge
  // that accepts tx_start and falls on the edge that re-enters IDLE.
  assign tx_busy      = (state_reg != IDLE);
  assign tx_done_tick = done_reg;
  assign tx           = tx_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
//
// Directed bench for uart_tx_ctrl. dut_a uses the default parameters.
// dut_b uses DBIT=7 and SB_TICK=32. Frames come from a table of
// {din, s_tick period, expected serial sequence}. Each expected sequence is
// written out by hand, first transmitted bit leftmost, and padded with 1s when
// the frame is shorter than 10 bits. Mid-frame tx_start, back-to-back frames
// and reset during a frame are driven as hand-written sequences.
//
// Timing: the clock rises at 5, 15, 25 and so on. Inputs are driven and
// outputs are sampled at the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  localparam int OS_T = 16;

  logic       clk        = 1'b0;
  logic       reset      = 1'b0;
  logic       s_tick     = 1'b0;
  logic       tx_start_a = 1'b0;
  logic       tx_start_b = 1'b0;
  logic [7:0] din_a      = 8'h00;
  logic [6:0] din_b      = 7'h00;
  logic       tx_a, busy_a, done_a;
  logic       tx_b, busy_b, done_b;

  int n_err    = 0;
  int n_checks = 0;

  uart_tx_ctrl #(.DBIT(8), .OS(16), .SB_TICK(16)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .tx_start     (tx_start_a),
    .din          (din_a),
    .tx_busy      (busy_a),
    .tx_done_tick (done_a),
    .tx           (tx_a)
  );

  uart_tx_ctrl #(.DBIT(7), .OS(16), .SB_TICK(32)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .tx_start     (tx_start_b),
    .din          (din_b),
    .tx_busy      (busy_b),
    .tx_done_tick (done_b),
    .tx           (tx_b)
  );

  always #5 clk = ~clk;

  // Time limit for the whole run: 50k clock cycles.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "time limit");
  end

  typedef struct {
    string      name;
    int         inst;
    logic [7:0] din;
    int         period;
    logic [9:0] seq;
    int         dbit;
    int         sb;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic logic get_tx(input int inst);
    return (inst == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic get_busy(input int inst);
    return (inst == 0) ? busy_a : busy_b;
  endfunction

  function automatic logic get_done(input int inst);
    return (inst == 0) ? done_a : done_b;
  endfunction

  task automatic drive(input int inst, input logic st, input logic [7:0] d, input logic tk);
    s_tick = tk;
    if (inst == 0) begin
      tx_start_a = st;
      din_a      = d;
    end else begin
      tx_start_b = st;
      din_b      = d[6:0];
    end
  endtask

  // Runs one frame and checks it cycle by cycle. On the following edge
  // s_tick is driven high when (c+1) % p == 0, so at falling edge c exactly
  // c/p ticks have been consumed since the accepting edge. The task ends at
  // the falling edge where the last tick has been consumed, so a following
  // call can start a back-to-back frame on the very next edge.
  //   hold     : keep tx_start high for the whole frame and drive alt on din
  //   glitch_c : cycle index of a one-cycle tx_start pulse with din=alt
  task automatic run_frame(input string name, input int inst, input logic [7:0] d,
                           input int p, input logic [9:0] seq, input int dbit,
                           input int sb, input bit hold, input logic [7:0] alt,
                           input int glitch_c);
    int         bad [10];
    int         busy_bad;
    int         done_bad;
    int         total;
    int         t;
    int         idx;
    int         c;
    logic       st;
    logic       tk;
    logic [7:0] dd;
    for (int k = 0; k < 10; k++) bad[k] = 0;
    busy_bad = 0;
    done_bad = 0;
    total    = (1 + dbit) * OS_T + sb;
    $display("frame %s: din=0x%02h period=%0d ticks=%0d", name, d, p, total);

    // Request the frame. s_tick is held high to show it is ignored while idle.
    drive(inst, 1'b1, d, 1'b1);
    @(posedge clk);
    @(negedge clk);

    c = 0;
    while ((c / p) < total) begin
      t   = c / p;
      idx = (t < (1 + dbit) * OS_T) ? (t / OS_T) : (1 + dbit);
      if (get_tx(inst) !== seq[9 - idx]) bad[idx]++;
      if (get_busy(inst) !== 1'b1) busy_bad++;
      if (get_done(inst) !== 1'b0) done_bad++;
      st = hold || (c == glitch_c);
      dd = (hold || (glitch_c >= 0 && c >= glitch_c)) ? alt : d;
      tk = (((c + 1) % p) == 0);
      drive(inst, st, dd, tk);
      @(negedge clk);
      c++;
    end

    for (int k = 0; k <= 1 + dbit; k++)
      check($sformatf("%s bit%0d wrong-cycles", name, k), bad[k], 0);
    check({name, " busy-low-in-frame cycles"}, busy_bad, 0);
    check({name, " done-early cycles"}, done_bad, 0);
    check({name, " end done"}, int'(get_done(inst)), 1);
    check({name, " end busy"}, int'(get_busy(inst)), 0);
    check({name, " end tx"}, int'(get_tx(inst)), 1);
  endtask

  // Line must sit idle with tx_start low even though s_tick keeps running.
  task automatic idle_check(input string name, input int inst, input int ncyc);
    int bad_cnt;
    bad_cnt = 0;
    drive(inst, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (get_tx(inst) !== 1'b1 || get_busy(inst) !== 1'b0 || get_done(inst) !== 1'b0)
        bad_cnt++;
    end
    $display("idle %s: %0d cycles", name, ncyc);
    check({name, " idle bad cycles"}, bad_cnt, 0);
  endtask

  initial begin
    vec_t vecs [5];
    vecs[0] = '{name:"d55_p1",   inst:0, din:8'h55, period:1, seq:10'b0101010101, dbit:8, sb:16};
    vecs[1] = '{name:"dA3_p4",   inst:0, din:8'hA3, period:4, seq:10'b0110001011, dbit:8, sb:16};
    vecs[2] = '{name:"dFF_p2",   inst:0, din:8'hFF, period:2, seq:10'b0111111111, dbit:8, sb:16};
    vecs[3] = '{name:"d41_sb32", inst:1, din:8'h41, period:1, seq:10'b0100000111, dbit:7, sb:32};
    vecs[4] = '{name:"d3C_p3",   inst:0, din:8'h3C, period:3, seq:10'b0001111001, dbit:8, sb:16};

    // Asynchronous reset before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("reset tx_a",   int'(tx_a),   1);
    check("reset busy_a", int'(busy_a), 0);
    check("reset done_a", int'(done_a), 0);
    check("reset tx_b",   int'(tx_b),   1);
    check("reset busy_b", int'(busy_b), 0);

    // A request made while reset is held must be ignored.
    tx_start_a = 1'b1;
    din_a      = 8'hAA;
    s_tick     = 1'b1;
    repeat (3) @(negedge clk);
    check("reset-held busy_a", int'(busy_a), 0);
    check("reset-held tx_a",   int'(tx_a),   1);
    tx_start_a = 1'b0;
    reset      = 1'b0;
    idle_check("post-init", 0, 4);

    // Table-driven frames.
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].name, vecs[i].inst, vecs[i].din, vecs[i].period, vecs[i].seq,
                vecs[i].dbit, vecs[i].sb, 1'b0, vecs[i].din, -1);
      idle_check({vecs[i].name, " after"}, vecs[i].inst, 20);
    end

    // tx_start with din=0xFF pulsed in the middle of a 0x00 frame: the frame
    // must stay all zeros and no second frame may follow.
    run_frame("d00_glitch", 0, 8'h00, 1, 10'b0000000001, 8, 16, 1'b0, 8'hFF, 40);
    idle_check("d00_glitch after", 0, 30);

    // tx_start held high: 0x0F, then 0xF0 accepted on the edge right after
    // the done pulse.
    run_frame("d0F_hold", 0, 8'h0F, 1, 10'b0111100001, 8, 16, 1'b1, 8'hF0, -1);
    run_frame("dF0_hold", 0, 8'hF0, 1, 10'b0000011111, 8, 16, 1'b1, 8'hF0, -1);
    idle_check("hold after", 0, 20);

    // Reset during the third data bit of a 0x00 frame.
    $display("frame reset_mid: din=0x00 period=1, reset at cycle 50");
    drive(0, 1'b1, 8'h00, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 1'b1);
    repeat (50) @(negedge clk);
    check("reset_mid pre tx",   int'(tx_a),   0);
    check("reset_mid pre busy", int'(busy_a), 1);
    reset = 1'b1;
    #1;
    check("reset_mid tx",   int'(tx_a),   1);
    check("reset_mid busy", int'(busy_a), 0);
    check("reset_mid done", int'(done_a), 0);
    @(negedge clk);
    reset = 1'b0;
    idle_check("reset_mid after", 0, 40);

    // The block is usable again after the aborted frame.
    run_frame("d55_again", 0, 8'h55, 1, 10'b0101010101, 8, 16, 1'b0, 8'h55, -1);
    idle_check("d55_again after", 0, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
